// File: rtl/hmmm_ram.sv
// ---------------------------------------------------------------------------
// hmmm_ram
// Main data/instruction memory for the Hmmm CPU. Single-port synchronous RAM
// of 2^ADDR_W x DATA_W words. It serves CPU reads and writes addressed by the
// memory address register. It also has a streaming program-loader port that
// fills memory sequentially from address 0 while the CPU is held off by busy.
//
// Optional feature (macro HMMM_RAM_CLEAR_EN): reset enters a CLEAR state. That
// state sweeps every word to zero before the block returns to IDLE.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ram_address         CPU word address (already registered upstream)
//   ram_in / data_in    CPU write strobe and write data
//   ram_out             CPU read strobe
//   data_out/data_valid registered read data, one-cycle valid pulse
//   load_start          begin a program load at address 0
//   load_valid/data     loader word handshake (with load_ready)
//   load_last           marks the final loader word
//   load_ready          loader word accepted this cycle
//   load_done           one-cycle pulse after the final loader word lands
//   busy                CPU accesses are not serviced (LOAD / CLEAR)
// ---------------------------------------------------------------------------
module hmmm_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ram_address,
    input  logic              ram_in,
    input  logic              ram_out,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

`ifdef HMMM_RAM_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;
    localparam state_e RESET_STATE = ST_CLEAR;
    localparam logic   RESET_BUSY  = 1'b1;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1
    } state_e;
    localparam state_e RESET_STATE = ST_IDLE;
    localparam logic   RESET_BUSY  = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              load_ready_q, load_ready_d;
    logic              load_done_q, load_done_d;
    logic              busy_q, busy_d;

    // Single memory write port shared by CPU, loader and clear sweep.
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;

    // Next-state, write-port selection and registered output values.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        load_done_d  = 1'b0;
        we_s         = 1'b0;
        waddr_s      = ram_address;
        wdata_s      = data_in;

        case (state_q)
            ST_IDLE: begin
                if (ram_in) begin
                    we_s = 1'b1;
                end else begin
                    we_s = 1'b0;
                end
                // The read sees the pre-edge contents, so a simultaneous
                // write at the same address returns the old word.
                if (ram_out) begin
                    data_out_d   = mem_q[ram_address];
                    data_valid_d = 1'b1;
                end else begin
                    data_out_d   = data_out_q;
                    data_valid_d = 1'b0;
                end
                // load_start only steers the state; the CPU strobes above are
                // still honoured in the same cycle.
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                if (load_valid) begin
                    we_s    = 1'b1;
                    waddr_s = ptr_q;
                    wdata_s = load_data;
                    if (load_last || (ptr_q == PTR_MAX)) begin
                        state_d     = ST_IDLE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                    // Saturate at the top so a full-depth load never wraps.
                    if (ptr_q != PTR_MAX) begin
                        ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end

`ifdef HMMM_RAM_CLEAR_EN
            ST_CLEAR: begin
                we_s    = 1'b1;
                waddr_s = ptr_q;
                wdata_s = '0;
                if (ptr_q == PTR_MAX) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_CLEAR;
                    ptr_d   = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered, so they are derived from the
        // state the block is about to enter.
        busy_d       = (state_d != ST_IDLE);
        load_ready_d = (state_d == ST_LOAD);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            ptr_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            busy_q       <= RESET_BUSY;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            load_ready_q <= load_ready_d;
            load_done_q  <= load_done_d;
            busy_q       <= busy_d;
        end
    end

    // Memory array; contents are not reset and writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (we_s && !rst) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign load_ready = load_ready_q;
    assign load_done  = load_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_hmmm_ram.sv
// ---------------------------------------------------------------------------
// tb_hmmm_ram
// Directed bench for hmmm_ram: CPU write/read, read-before-write, stalled load,
// full-depth load, reset mid-load and (with HMMM_RAM_CLEAR_EN) the clear sweep.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that
// same point.
// ---------------------------------------------------------------------------
module tb_hmmm_ram;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

`ifdef HMMM_RAM_CLEAR_EN
    localparam logic RST_BUSY = 1'b1;
`else
    localparam logic RST_BUSY = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_in;
    logic              ram_out;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic              busy;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;

    hmmm_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ram_address(ram_address),
        .ram_in     (ram_in),
        .ram_out    (ram_out),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every cycle in which load_done is high.
    always @(posedge clk) begin
        if (load_done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [15:0] d);
        ram_address = addr;
        data_in     = d;
        ram_in      = 1'b1;
        step();
        ram_in      = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [7:0] addr, input logic [15:0] exp);
        ram_address = addr;
        ram_out     = 1'b1;
        step();
        ram_out     = 1'b0;
        check({tag, "_data"}, {16'h0000, data_out}, {16'h0000, exp});
        check({tag, "_valid"}, {31'd0, data_valid}, 32'd1);
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Waits for the clear sweep to finish and checks it takes 256 cycles.
    task automatic wait_sweep(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check(tag, n, 32'd256);
    endtask

    initial begin
        logic [15:0] exp0;
        logic [15:0] exp1;

        rst = 1'b1; ram_address = 8'h00; ram_in = 1'b0; ram_out = 1'b0;
        data_in = 16'h0000; load_start = 1'b0; load_valid = 1'b0;
        load_data = 16'h0000; load_last = 1'b0;
        step();
        step();

        // Reset state
        check("rst_data_out",   {16'h0000, data_out}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd0);
        check("rst_load_done",  {31'd0, load_done}, 32'd0);
        check("rst_busy",       {31'd0, busy}, {31'd0, RST_BUSY});
        rst = 1'b0;
`ifdef HMMM_RAM_CLEAR_EN
        wait_sweep("init_clear_cycles");
`endif

        // Write then read
        cpu_write(8'h10, 16'hA5C3);
        check("wr_no_valid", {31'd0, data_valid}, 32'd0);
        cpu_read("rd10", 8'h10, 16'hA5C3);
        step();
        check("rd10_valid_drop", {31'd0, data_valid}, 32'd0);
        check("rd10_hold", {16'h0000, data_out}, 32'h0000A5C3);

        // Simultaneous strobes: read-before-write
        cpu_write(8'h20, 16'h1111);
        ram_address = 8'h20; data_in = 16'h2222; ram_in = 1'b1; ram_out = 1'b1;
        step();
        ram_in = 1'b0; ram_out = 1'b0;
        check("rbw_old", {16'h0000, data_out}, 32'h00001111);
        check("rbw_valid", {31'd0, data_valid}, 32'd1);
        cpu_read("rbw_new", 8'h20, 16'h2222);

        // Load with stalls
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("ld_busy", {31'd0, busy}, 32'd1);
        check("ld_ready", {31'd0, load_ready}, 32'd1);
        load_word(16'h0001, 1'b0);
        ram_address = 8'h10; ram_out = 1'b1; ram_in = 1'b1; data_in = 16'h7777;
        step();
        ram_out = 1'b0; ram_in = 1'b0;
        check("ld_rd_ignored_valid", {31'd0, data_valid}, 32'd0);
        check("ld_rd_ignored_data", {16'h0000, data_out}, 32'h00002222);
        check("ld_stall_busy", {31'd0, busy}, 32'd1);
        load_word(16'h0002, 1'b0);
        step();
        load_word(16'h0003, 1'b1);
        check("ld_done_pulse", {31'd0, load_done}, 32'd1);
        check("ld_busy_drop", {31'd0, busy}, 32'd0);
        check("ld_ready_drop", {31'd0, load_ready}, 32'd0);
        step();
        check("ld_done_one_cycle", {31'd0, load_done}, 32'd0);
        cpu_read("ld_m0", 8'h00, 16'h0001);
        cpu_read("ld_m1", 8'h01, 16'h0002);
        cpu_read("ld_m2", 8'h02, 16'h0003);
        cpu_read("ld_cpu_wr_ignored", 8'h10, 16'hA5C3);

        // Full-depth load without load_last
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            load_word(16'h1000 + 16'(i), 1'b0);
            if (i == 254) check("full_busy_254", {31'd0, busy}, 32'd1);
        end
        check("full_done", {31'd0, load_done}, 32'd1);
        check("full_busy_drop", {31'd0, busy}, 32'd0);
        load_word(16'hDEAD, 1'b0);
        check("full_no_second_done", {31'd0, load_done}, 32'd0);
        cpu_read("full_m00", 8'h00, 16'h1000);
        cpu_read("full_m80", 8'h80, 16'h1080);
        cpu_read("full_mff", 8'hFF, 16'h10FF);
        check("done_count_2", done_cnt, 32'd2);

        // Reset mid-load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_word(16'h00A0, 1'b0);
        load_word(16'h00A1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, {31'd0, RST_BUSY});
        check("mid_rst_ready", {31'd0, load_ready}, 32'd0);
        check("mid_rst_data_out", {16'h0000, data_out}, 32'd0);
`ifdef HMMM_RAM_CLEAR_EN
        wait_sweep("mid_rst_clear_cycles");
        exp0 = 16'h0000;
        exp1 = 16'h0000;
`else
        exp0 = 16'h00A0;
        exp1 = 16'h00A1;
`endif
        step();
        step();
        check("mid_rst_no_done", done_cnt, 32'd2);
        cpu_read("mid_m0", 8'h00, exp0);
        cpu_read("mid_m1", 8'h01, exp1);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_word(16'h00B0, 1'b1);
        check("reload_done", {31'd0, load_done}, 32'd1);
        cpu_read("reload_m0", 8'h00, 16'h00B0);
        cpu_read("reload_m1", 8'h01, exp1);
        check("done_count_3", done_cnt, 32'd3);

`ifdef HMMM_RAM_CLEAR_EN
        // Clear sweep wipes previously written data
        cpu_write(8'h42, 16'hBEEF);
        cpu_read("clr_pre", 8'h42, 16'hBEEF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd1);
        check("clr_ready", {31'd0, load_ready}, 32'd0);
        wait_sweep("clr_cycles");
        cpu_read("clr_m42", 8'h42, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
